// File: rtl/alu_result_checker.sv
// -----------------------------------------------------------------------------
// alu_result_checker
//
// Consuming end of the 4-bit ALU stimulus sweep. Each accepted vector
// {op, n1, n2, result, ccr} is registered together with its golden response
// (stage 1). The following cycle it is compared and the pass/fail counters and
// the first-mismatch capture are updated (stage 2). After SWEEP_LEN vectors
// have been accepted and the pipeline has drained, the checker sits in DONE.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle pulse, honoured only in IDLE or DONE
//   in_valid_i     vector inputs carry a valid vector this cycle
//   in_ready_o     checker accepts a vector this cycle
//   n1_i, n2_i     ALU operands (4 bits each)
//   op_i           ALU operator (3 bits)
//   result_i       ALU result under test (4 bits)
//   ccr_i          ALU flags under test, {carry, overflow}
//   busy_o         state is RUN
//   done_o         state is DONE (level, held until start or reset)
//   pass_count_o   matching vectors this run
//   fail_count_o   mismatching vectors this run
//   first_fail_o   {2'b00, op, n1, n2, result, ccr} of the first mismatch
//   first_exp_o    expected {result, ccr} for first_fail_o
//   fail_seen_o    at least one mismatch this run
// -----------------------------------------------------------------------------
module alu_result_checker #(
   parameter int unsigned SWEEP_LEN = 256
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [3:0]  n1_i,
   input  logic [3:0]  n2_i,
   input  logic [2:0]  op_i,
   input  logic [3:0]  result_i,
   input  logic [1:0]  ccr_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [8:0]  pass_count_o,
   output logic [8:0]  fail_count_o,
   output logic [18:0] first_fail_o,
   output logic [5:0]  first_exp_o,
   output logic        fail_seen_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [8:0] LEN = 9'(SWEEP_LEN);

   // Golden ALU response {result[3:0], carry, overflow}, 4-bit wrap.
   function automatic logic [5:0] golden_f(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
      logic [4:0] sum;
      logic [3:0] r;
      logic       c;
      logic       v;
      sum = 5'd0;
      r   = 4'd0;
      c   = 1'b0;
      v   = 1'b0;
      case (op)
         3'b000: begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[3:0];
            c   = sum[4];
            // same-sign operands producing an opposite-sign result
            v   = (a[3] == b[3]) && (r[3] != a[3]);
         end
         3'b001: begin
            r = a - b;
            c = (a < b);
            // different-sign operands where the result sign differs from n1
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         3'b010: r = a & b;
         3'b011: r = a | b;
         3'b100: r = a ^ b;
         3'b101: r = ~a;
         3'b110: begin
            r = {a[2:0], 1'b0};
            c = a[3];
            v = a[3] ^ a[2];
         end
         3'b111: begin
            sum = {1'b0, a} + 5'd1;
            r   = sum[3:0];
            c   = sum[4];
            v   = (a == 4'b0111);
         end
         default: begin
            r = 4'd0;
            c = 1'b0;
            v = 1'b0;
         end
      endcase
      return {r, c, v};
   endfunction

   logic [1:0]  state_q,   state_d;
   logic [8:0]  acc_cnt_q, acc_cnt_d;
   logic        s1_vld_q,  s1_vld_d;
   logic [16:0] s1_vec_q,  s1_vec_d;
   logic [5:0]  s1_exp_q,  s1_exp_d;
   logic [8:0]  pass_q,    pass_d;
   logic [8:0]  fail_q,    fail_d;
   logic        seen_q,    seen_d;
   logic [16:0] ff_q,      ff_d;
   logic [5:0]  fe_q,      fe_d;

   logic in_ready_s;
   logic accept_s;
   logic match_s;
   logic clear_s;

   // Handshake qualifiers and the stage-2 compare result.
   always_comb begin
      in_ready_s = (state_q == ST_RUN) && (acc_cnt_q < LEN);
      accept_s   = in_valid_i && in_ready_s;
      match_s    = (s1_vec_q[5:0] == s1_exp_q);
   end

   // Next-state logic: FSM, accept counter, stage 1 and stage 2.
   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      s1_vld_d  = 1'b0;
      s1_vec_d  = s1_vec_q;
      s1_exp_d  = s1_exp_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      seen_d    = seen_q;
      ff_d      = ff_q;
      fe_d      = fe_q;
      clear_s   = 1'b0;

      // Stage 2: score the vector held in stage 1.
      if (s1_vld_q) begin
         if (match_s) begin
            pass_d = pass_q + 9'd1;
         end else begin
            fail_d = fail_q + 9'd1;
            // only the first mismatch of a run is captured
            if (!seen_q) begin
               seen_d = 1'b1;
               ff_d   = s1_vec_q;
               fe_d   = s1_exp_q;
            end else begin
               seen_d = seen_q;
            end
         end
      end else begin
         pass_d = pass_q;
      end

      // Stage 1: register the accepted vector with its golden response.
      if (accept_s) begin
         s1_vld_d  = 1'b1;
         s1_vec_d  = {op_i, n1_i, n2_i, result_i, ccr_i};
         s1_exp_d  = golden_f(op_i, n1_i, n2_i);
         acc_cnt_d = acc_cnt_q + 9'd1;
      end else begin
         s1_vld_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               clear_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // At the edge after the last accept, stage 2 scores the final
            // vector, so the pipeline is empty as the state enters DONE.
            if (acc_cnt_q == LEN) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start_i) begin
               state_d = ST_RUN;
               clear_s = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Entering RUN starts a fresh run.
      if (clear_s) begin
         acc_cnt_d = 9'd0;
         s1_vld_d  = 1'b0;
         pass_d    = 9'd0;
         fail_d    = 9'd0;
         seen_d    = 1'b0;
         ff_d      = 17'd0;
         fe_d      = 6'd0;
      end else begin
         acc_cnt_d = acc_cnt_d;
      end
   end

   // State and pipeline registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         acc_cnt_q <= 9'd0;
         s1_vld_q  <= 1'b0;
         s1_vec_q  <= 17'd0;
         s1_exp_q  <= 6'd0;
         pass_q    <= 9'd0;
         fail_q    <= 9'd0;
         seen_q    <= 1'b0;
         ff_q      <= 17'd0;
         fe_q      <= 6'd0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         s1_vld_q  <= s1_vld_d;
         s1_vec_q  <= s1_vec_d;
         s1_exp_q  <= s1_exp_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         seen_q    <= seen_d;
         ff_q      <= ff_d;
         fe_q      <= fe_d;
      end
   end

   // Outputs are taken straight from registers.
   always_comb begin
      in_ready_o   = in_ready_s;
      busy_o       = (state_q == ST_RUN);
      done_o       = (state_q == ST_DONE);
      pass_count_o = pass_q;
      fail_count_o = fail_q;
      first_fail_o = {2'b00, ff_q};
      first_exp_o  = fe_q;
      fail_seen_o  = seen_q;
   end

endmodule
